// File: rtl/seg7_p2s_multi.sv
// Parallel-to-serial shifter driving CHANNELS external shift-register chains on a shared divided s_clk.
// Optional macro P2S_LATCH_EN adds a LATCH state that strobes s_latch after the last bit.
module seg7_p2s_multi #(
  parameter int unsigned DATA_BITS = 16,
  parameter int unsigned CHANNELS  = 1,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned DIR       = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  input  logic [CHANNELS*DATA_BITS-1:0]   pdata,
  output logic                            busy,
  output logic                            done,
  output logic                            s_clk,
  output logic                            s_clrn,
  output logic                            s_latch,
  output logic [CHANNELS-1:0]             sout
);

  localparam int unsigned TOT = CHANNELS * DATA_BITS;
  localparam int unsigned IW  = $clog2(TOT);
  localparam int unsigned DW  = $clog2(CLK_DIV + 1);
  localparam int unsigned BW  = $clog2(DATA_BITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd3
`ifdef P2S_LATCH_EN
    , S_LATCH = 2'd2
`endif
  } state_t;

  state_t            state, state_nxt;
  logic [DW-1:0]     div_cnt, div_nxt;
  logic [BW-1:0]     bit_cnt, bit_nxt;
  logic              phase_hi, phase_nxt;
  logic [TOT-1:0]    shadow, shadow_nxt;
  logic              busy_nxt, done_nxt, s_clk_nxt;
  logic [CHANNELS-1:0] sout_nxt;
`ifdef P2S_LATCH_EN
  logic              s_latch_q, s_latch_nxt;
`endif

  // Bit of every lane at shift position b, honouring DIR.
  function automatic logic [CHANNELS-1:0] lane_bits(input logic [TOT-1:0] d,
                                                     input logic [BW-1:0] b);
    logic [CHANNELS-1:0] r;
    int unsigned         idx;
    logic [IW-1:0]       ix;
    idx = 32'(b);
    if (DIR == 0) idx = DATA_BITS - 1 - idx;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      ix   = IW'(c * DATA_BITS + idx);
      r[c] = d[ix];
    end
    return r;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_nxt  = state;
    div_nxt    = div_cnt;
    bit_nxt    = bit_cnt;
    phase_nxt  = phase_hi;
    shadow_nxt = shadow;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    s_clk_nxt  = s_clk;
    sout_nxt   = sout;
`ifdef P2S_LATCH_EN
    s_latch_nxt = s_latch_q;
`endif
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_nxt  = S_SHIFT;
          shadow_nxt = pdata;
          div_nxt    = '0;
          bit_nxt    = '0;
          phase_nxt  = 1'b0;
          busy_nxt   = 1'b1;
          s_clk_nxt  = 1'b0;
          sout_nxt   = lane_bits(pdata, '0);
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_nxt = S_IDLE;
          div_nxt   = '0;
          bit_nxt   = '0;
          phase_nxt = 1'b0;
          busy_nxt  = 1'b0;
          s_clk_nxt = 1'b0;
          sout_nxt  = '0;
        end else if (div_cnt == DIV_LAST) begin
          div_nxt = '0;
          if (!phase_hi) begin
            phase_nxt = 1'b1;
            s_clk_nxt = 1'b1;
          end else if (bit_cnt == BIT_LAST) begin
            phase_nxt = 1'b0;
            s_clk_nxt = 1'b0;
`ifdef P2S_LATCH_EN
            state_nxt   = S_LATCH;
            s_latch_nxt = 1'b1;
`else
            state_nxt = S_DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
`endif
          end else begin
            bit_nxt   = bit_cnt + BW'(1);
            phase_nxt = 1'b0;
            s_clk_nxt = 1'b0;
            sout_nxt  = lane_bits(shadow, bit_cnt + BW'(1));
          end
        end else begin
          div_nxt = div_cnt + DW'(1);
        end
      end
`ifdef P2S_LATCH_EN
      S_LATCH: begin
        if (abort) begin
          state_nxt   = S_IDLE;
          div_nxt     = '0;
          bit_nxt     = '0;
          busy_nxt    = 1'b0;
          s_clk_nxt   = 1'b0;
          s_latch_nxt = 1'b0;
          sout_nxt    = '0;
        end else if (div_cnt == DIV_LAST) begin
          state_nxt   = S_DONE;
          div_nxt     = '0;
          s_latch_nxt = 1'b0;
          busy_nxt    = 1'b0;
          done_nxt    = 1'b1;
        end else begin
          div_nxt = div_cnt + DW'(1);
        end
      end
`endif
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; s_clrn releases one edge after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      phase_hi <= 1'b0;
      shadow   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      s_clk    <= 1'b0;
      sout     <= '0;
      s_clrn   <= 1'b0;
`ifdef P2S_LATCH_EN
      s_latch_q <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      div_cnt  <= div_nxt;
      bit_cnt  <= bit_nxt;
      phase_hi <= phase_nxt;
      shadow   <= shadow_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      s_clk    <= s_clk_nxt;
      sout     <= sout_nxt;
      s_clrn   <= 1'b1;
`ifdef P2S_LATCH_EN
      s_latch_q <= s_latch_nxt;
`endif
    end
  end

`ifdef P2S_LATCH_EN
  assign s_latch = s_latch_q;
`else
  assign s_latch = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_p2s_multi.sv
// Self-checking bench for seg7_p2s_multi: two instances (1 lane DIV=2 MSB-first, 3 lanes DIV=1 LSB-first).
module tb_seg7_p2s_multi;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, abort0 = 1'b0;
  logic [15:0] pdata0 = '0;
  logic        busy0, done0, s_clk0, s_clrn0, s_latch0;
  logic [0:0]  sout0;

  logic        start1 = 1'b0, abort1 = 1'b0;
  logic [47:0] pdata1 = '0;
  logic        busy1, done1, s_clk1, s_clrn1, s_latch1;
  logic [2:0]  sout1;

  seg7_p2s_multi #(.DATA_BITS(16), .CHANNELS(1), .CLK_DIV(2), .DIR(0)) d0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .pdata(pdata0),
    .busy(busy0), .done(done0), .s_clk(s_clk0), .s_clrn(s_clrn0),
    .s_latch(s_latch0), .sout(sout0));

  seg7_p2s_multi #(.DATA_BITS(16), .CHANNELS(3), .CLK_DIV(1), .DIR(1)) d1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .pdata(pdata1),
    .busy(busy1), .done(done1), .s_clk(s_clk1), .s_clrn(s_clrn1),
    .s_latch(s_latch1), .sout(sout1));

  int tests = 0;
  int fails = 0;
  int dcnt0 = 0, dcnt1 = 0;
  int unexp0 = 0, unexp1 = 0;
  logic prev0 = 1'b0, prev1 = 1'b0;
  logic [2:0] q0[$];
  logic [2:0] q1[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard: compare lanes against expected bits on every s_clk rising edge.
  always @(negedge clk) begin
    logic [2:0] e;
    if (s_clk0 === 1'b1 && prev0 === 1'b0) begin
      if (q0.size() == 0) unexp0++;
      else begin
        e = q0.pop_front();
        check("d0 sout at s_clk rise", 64'(sout0), 64'(e[0]));
      end
    end
    if (s_clk1 === 1'b1 && prev1 === 1'b0) begin
      if (q1.size() == 0) unexp1++;
      else begin
        e = q1.pop_front();
        check("d1 sout at s_clk rise", 64'(sout1), 64'(e));
      end
    end
    prev0 = s_clk0;
    prev1 = s_clk1;
    if (done0 === 1'b1) dcnt0++;
    if (done1 === 1'b1) dcnt1++;
  end

  function automatic logic get_done(input int w);
    return (w == 0) ? done0 : done1;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 0) ? busy0 : busy1;
  endfunction
  function automatic int get_dcnt(input int w);
    return (w == 0) ? dcnt0 : dcnt1;
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w == 0) start0 = v; else start1 = v;
  endtask
  task automatic set_pdata(input int w, input logic [47:0] pd);
    if (w == 0) pdata0 = pd[15:0]; else pdata1 = pd;
  endtask

  // Expected bit stream for one transfer, straight from the lane/bit-order definition.
  task automatic push_exp(input int w, input logic [47:0] pd);
    int ch, dir, idx;
    logic [2:0] e;
    ch  = (w == 0) ? 1 : 3;
    dir = (w == 0) ? 0 : 1;
    for (int k = 0; k < 16; k++) begin
      e   = '0;
      idx = (dir != 0) ? k : 15 - k;
      for (int c = 0; c < ch; c++) e[c] = pd[c*16 + idx];
      if (w == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  // Count edges until done (accept edge counts as 1); optional one-cycle start pulse at restart_at.
  task automatic wait_done(input int w, input int restart_at, output int cnt, output bit busy_ok);
    cnt = 1;
    busy_ok = 1'b1;
    while (get_done(w) !== 1'b1 && cnt < 300) begin
      if (get_busy(w) !== 1'b1) busy_ok = 1'b0;
      set_start(w, (cnt == restart_at));
      @(posedge clk); #1;
      cnt++;
    end
    set_start(w, 1'b0);
  endtask

  task automatic run_xfer(input int w, input logic [47:0] pd, input int lat, input int restart_at);
    int cnt, d_before;
    bit busy_ok;
    push_exp(w, pd);
    d_before = get_dcnt(w);
    @(negedge clk);
    set_pdata(w, pd);
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    set_pdata(w, ~pd);
    wait_done(w, restart_at, cnt, busy_ok);
    check("latency accept->done", 64'(cnt), 64'(lat));
    check("busy continuous", 64'(busy_ok), 64'(1));
    check("busy low in done cycle", 64'(get_busy(w)), 64'(0));
    @(posedge clk); #1;
    check("done one cycle wide", 64'(get_done(w)), 64'(0));
    repeat (20) @(posedge clk);
    #1;
    check("exactly one done", 64'(get_dcnt(w) - d_before), 64'(1));
    check("idle after transfer", 64'(get_busy(w)), 64'(0));
    check("all bits shifted", 64'((w == 0) ? q0.size() : q1.size()), 64'(0));
  endtask

  typedef struct {
    int          w;
    logic [47:0] pd;
    int          lat;
    int          restart;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int cnt, d_before;
    bit busy_ok;
    vecs[0] = '{0, 48'h0000_0000_A5C3, 65, 0};
    vecs[1] = '{1, 48'h0000_0000_0001, 33, 0};
    vecs[2] = '{1, {16'hFFFF, 16'h0000, 16'h1234}, 33, 0};
    vecs[3] = '{0, 48'h0000_0000_0001, 65, 0};
    vecs[4] = '{0, 48'h0000_0000_8000, 65, 21};
    vecs[5] = '{1, 48'h5A5A_3C3C_F00F, 33, 11};
    vecs[6] = '{0, 48'h0000_0000_FFFF, 65, 0};

    // Reset values, then s_clrn release.
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy0), 64'(0));
    check("reset done", 64'(done0), 64'(0));
    check("reset s_clk", 64'(s_clk0), 64'(0));
    check("reset s_latch", 64'(s_latch0), 64'(0));
    check("reset sout", 64'(sout0), 64'(0));
    check("reset s_clrn", 64'(s_clrn0), 64'(0));
    check("reset d1 sout", 64'(sout1), 64'(0));
    check("reset d1 s_clrn", 64'(s_clrn1), 64'(0));
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("s_clrn release", 64'(s_clrn0), 64'(1));
    check("d1 s_clrn release", 64'(s_clrn1), 64'(1));

    foreach (vecs[i]) run_xfer(vecs[i].w, vecs[i].pd, vecs[i].lat, vecs[i].restart);

    // Abort mid bit 8: outputs clear, 8 bits already out, no done.
    push_exp(0, 48'h5A5A);
    d_before = dcnt0;
    @(negedge clk); pdata0 = 16'h5A5A; start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0; cnt = 1;
    while (cnt < 34) begin @(posedge clk); #1; cnt++; end
    abort0 = 1'b1;
    @(posedge clk); #1; abort0 = 1'b0;
    check("abort busy", 64'(busy0), 64'(0));
    check("abort s_clk", 64'(s_clk0), 64'(0));
    check("abort sout", 64'(sout0), 64'(0));
    check("abort bits remaining", 64'(q0.size()), 64'(8));
    q0.delete();
    repeat (80) @(posedge clk);
    #1;
    check("abort no done", 64'(dcnt0 - d_before), 64'(1'b0));
    run_xfer(0, 48'hC33C, 65, 0);

    // Abort and start together in IDLE: abort wins.
    d_before = dcnt0;
    @(negedge clk); start0 = 1'b1; abort0 = 1'b1; pdata0 = 16'h1111;
    @(posedge clk); #1; start0 = 1'b0; abort0 = 1'b0;
    check("abort+start no accept", 64'(busy0), 64'(0));
    repeat (10) @(posedge clk);
    #1;
    check("abort+start no done", 64'(dcnt0 - d_before), 64'(0));

    // Start held high re-triggers one cycle after DONE.
    push_exp(1, 48'h0F0F_F0F0_1357);
    push_exp(1, 48'h0F0F_F0F0_1357);
    @(negedge clk); pdata1 = 48'h0F0F_F0F0_1357; start1 = 1'b1;
    @(posedge clk); #1;
    cnt = 1;
    while (done1 !== 1'b1 && cnt < 300) begin @(posedge clk); #1; cnt++; end
    check("held start first latency", 64'(cnt), 64'(33));
    @(posedge clk); #1;
    check("idle cycle after done", 64'(busy1), 64'(0));
    @(posedge clk); #1;
    check("held start retriggers", 64'(busy1), 64'(1));
    start1 = 1'b0;
    wait_done(1, 0, cnt, busy_ok);
    check("retrigger latency", 64'(cnt), 64'(33));
    check("retrigger busy continuous", 64'(busy_ok), 64'(1));
    repeat (5) @(posedge clk);
    #1;
    check("retrigger bits shifted", 64'(q1.size()), 64'(0));

    // Reset mid-SHIFT for one cycle.
    push_exp(0, 48'h9999);
    d_before = dcnt0;
    @(negedge clk); pdata0 = 16'h9999; start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0; cnt = 1;
    while (cnt < 20) begin @(posedge clk); #1; cnt++; end
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("mid rst busy", 64'(busy0), 64'(0));
    check("mid rst s_clk", 64'(s_clk0), 64'(0));
    check("mid rst sout", 64'(sout0), 64'(0));
    check("mid rst s_clrn low", 64'(s_clrn0), 64'(0));
    check("mid rst done", 64'(done0), 64'(0));
    @(posedge clk); #1;
    check("mid rst s_clrn high", 64'(s_clrn0), 64'(1));
    q0.delete();
    repeat (80) @(posedge clk);
    #1;
    check("mid rst no done", 64'(dcnt0 - d_before), 64'(0));
    check("mid rst stays idle", 64'(busy0), 64'(0));

    check("d0 latch strobe unused", 64'(s_latch0), 64'(0));
    check("d0 unexpected s_clk rises", 64'(unexp0), 64'(0));
    check("d1 unexpected s_clk rises", 64'(unexp1), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
